pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Five-stage pipeline hazard unit: ID/EX, EX/MEM, MEM/WB stage registers, load-use stall,
// EX/MEM and MEM/WB operand forwarding. Define PIPE_HAZARD_WB_BYPASS_EN for the WB-to-ID bypass.
module pipe_hazard_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    output logic              stall,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_AW-1:0] idex_rs_q, idex_rs_d;
    logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
    logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
    logic              idex_we_q, idex_we_d;
    logic              idex_mr_q, idex_mr_d;
    logic [DATA_W-1:0] idex_rsd_q, idex_rsd_d;
    logic [DATA_W-1:0] idex_rtd_q, idex_rtd_d;

    logic [REG_AW-1:0] exmem_rd_q;
    logic              exmem_we_q;
    logic              exmem_mr_q;
    logic [DATA_W-1:0] exmem_alu_q;

    logic [REG_AW-1:0] memwb_rd_q;
    logic              memwb_we_q;
    logic              memwb_mr_q;
    logic [DATA_W-1:0] memwb_alu_q;
    logic [DATA_W-1:0] memwb_ld_q;

    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              load_use;
    logic              exmem_fwd_a, exmem_fwd_b;
    logic              memwb_fwd_a, memwb_fwd_b;
    logic [DATA_W-1:0] cap_rs_data, cap_rt_data;

    // Hazard detection only looks at the load sitting in ID/EX; one bubble puts it in MEM/WB.
    always_comb begin
        load_use = idex_mr_q && idex_we_q && (idex_rd_q != '0) &&
                   ((idex_rd_q == id_rs) || (id_uses_rt && (idex_rd_q == id_rt)));
        stall    = id_valid && load_use && !flush;
    end

    always_comb begin
        wb_we   = memwb_we_q && (memwb_rd_q != '0);
        wb_addr = memwb_rd_q;
        wb_data = memwb_mr_q ? memwb_ld_q : memwb_alu_q;
    end

    always_comb begin
        exmem_fwd_a = exmem_we_q && (exmem_rd_q != '0) && (exmem_rd_q == idex_rs_q);
        exmem_fwd_b = exmem_we_q && (exmem_rd_q != '0) && (exmem_rd_q == idex_rt_q);
        memwb_fwd_a = memwb_we_q && (memwb_rd_q != '0) && (memwb_rd_q == idex_rs_q);
        memwb_fwd_b = memwb_we_q && (memwb_rd_q != '0) && (memwb_rd_q == idex_rt_q);

        if (exmem_fwd_a)      ex_op_a = exmem_alu_q;
        else if (memwb_fwd_a) ex_op_a = wb_data;
        else                  ex_op_a = idex_rsd_q;

        if (exmem_fwd_b)      ex_op_b = exmem_alu_q;
        else if (memwb_fwd_b) ex_op_b = wb_data;
        else                  ex_op_b = idex_rtd_q;
    end

    always_comb begin
`ifdef PIPE_HAZARD_WB_BYPASS_EN
        cap_rs_data = (wb_we && (wb_addr == id_rs)) ? wb_data : id_rs_data;
        cap_rt_data = (wb_we && (wb_addr == id_rt)) ? wb_data : id_rt_data;
`else
        cap_rs_data = id_rs_data;
        cap_rt_data = id_rt_data;
`endif
    end

    always_comb begin
        idex_rs_d  = '0;
        idex_rt_d  = '0;
        idex_rd_d  = '0;
        idex_we_d  = 1'b0;
        idex_mr_d  = 1'b0;
        idex_rsd_d = '0;
        idex_rtd_d = '0;
        if (id_valid && !stall && !flush) begin
            idex_rs_d  = id_rs;
            idex_rt_d  = id_rt;
            idex_rd_d  = id_rd;
            idex_we_d  = id_reg_write;
            idex_mr_d  = id_mem_read;
            idex_rsd_d = cap_rs_data;
            idex_rtd_d = cap_rt_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
            idex_rd_q   <= '0;
            idex_we_q   <= 1'b0;
            idex_mr_q   <= 1'b0;
            idex_rsd_q  <= '0;
            idex_rtd_q  <= '0;
            exmem_rd_q  <= '0;
            exmem_we_q  <= 1'b0;
            exmem_mr_q  <= 1'b0;
            exmem_alu_q <= '0;
            memwb_rd_q  <= '0;
            memwb_we_q  <= 1'b0;
            memwb_mr_q  <= 1'b0;
            memwb_alu_q <= '0;
            memwb_ld_q  <= '0;
            cnt_q       <= '0;
        end else begin
            idex_rs_q   <= idex_rs_d;
            idex_rt_q   <= idex_rt_d;
            idex_rd_q   <= idex_rd_d;
            idex_we_q   <= idex_we_d;
            idex_mr_q   <= idex_mr_d;
            idex_rsd_q  <= idex_rsd_d;
            idex_rtd_q  <= idex_rtd_d;
            exmem_rd_q  <= idex_rd_q;
            exmem_we_q  <= idex_we_q;
            exmem_mr_q  <= idex_mr_q;
            exmem_alu_q <= ex_alu_result;
            memwb_rd_q  <= exmem_rd_q;
            memwb_we_q  <= exmem_we_q;
            memwb_mr_q  <= exmem_mr_q;
            memwb_alu_q <= exmem_alu_q;
            memwb_ld_q  <= mem_load_data;
            cnt_q       <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, ex_alu_result, mem_load_data;

  logic          stall, wb_we;
  logic [DW-1:0] ex_op_a, ex_op_b, wb_data;
  logic [AW-1:0] wb_addr;
  logic [15:0]   stall_cnt;

  logic          s_stall, s_wb_we;
  logic [DW-1:0] s_ex_op_a, s_ex_op_b, s_wb_data;
  logic [AW-1:0] s_wb_addr;
  logic [1:0]    s_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .flush(flush), .ex_alu_result(ex_alu_result), .mem_load_data(mem_load_data),
    .stall(stall), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  pipe_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .flush(flush), .ex_alu_result(ex_alu_result), .mem_load_data(mem_load_data),
    .stall(s_stall), .ex_op_a(s_ex_op_a), .ex_op_b(s_ex_op_b), .wb_we(s_wb_we),
    .wb_addr(s_wb_addr), .wb_data(s_wb_data), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    bit            v;
    bit            wr;
    bit            ld;
    logic [AW-1:0] rd, rs, rt;
    logic [DW-1:0] rsd, rtd, alu, lddata;
  } rec_t;

  rec_t m[3];
  int   stalls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t bubble();
    rec_t r;
    r.v = 0; r.wr = 0; r.ld = 0;
    r.rd = '0; r.rs = '0; r.rt = '0;
    r.rsd = '0; r.rtd = '0; r.alu = '0; r.lddata = '0;
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_wb_data();
    return m[2].ld ? m[2].lddata : m[2].alu;
  endfunction

  function automatic logic ref_wb_we();
    return m[2].wr && (m[2].rd != 0);
  endfunction

  function automatic logic [DW-1:0] ref_operand(input logic [AW-1:0] r, input logic [DW-1:0] own);
    if (r != 0) begin
      if (m[1].wr && m[1].rd == r) return m[1].alu;
      if (m[2].wr && m[2].rd == r) return ref_wb_data();
    end
    return own;
  endfunction

  function automatic logic ref_stall();
    if (!id_valid || flush) return 1'b0;
    if (!(m[0].wr && m[0].ld) || m[0].rd == 0) return 1'b0;
    return (m[0].rd == id_rs) || (id_uses_rt && m[0].rd == id_rt);
  endfunction

  task automatic clear_model();
    for (int unsigned k = 0; k < 3; k++) m[k] = bubble();
    stalls = 0;
  endtask

  task automatic sample();
    logic [15:0] e16;
    logic [1:0]  e2;
    @(negedge clk);
    e16 = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
    e2  = (stalls > 3) ? 2'd3 : 2'(stalls);
    chk("stall", stall, ref_stall());
    chk("wb_we", wb_we, ref_wb_we());
    chk("wb_addr", wb_addr, m[2].rd);
    chk("wb_data", wb_data, ref_wb_data());
    chk("stall_cnt", stall_cnt, e16);
    chk("sat_stall", s_stall, ref_stall());
    chk("sat_wb_we", s_wb_we, ref_wb_we());
    chk("sat_wb_addr", s_wb_addr, m[2].rd);
    chk("sat_wb_data", s_wb_data, ref_wb_data());
    chk("sat_stall_cnt", s_stall_cnt, e2);
    if (m[0].v) begin
      chk("ex_op_a", ex_op_a, ref_operand(m[0].rs, m[0].rsd));
      chk("ex_op_b", ex_op_b, ref_operand(m[0].rt, m[0].rtd));
      chk("sat_ex_op_a", s_ex_op_a, ref_operand(m[0].rs, m[0].rsd));
      chk("sat_ex_op_b", s_ex_op_b, ref_operand(m[0].rt, m[0].rtd));
    end
  endtask

  task automatic advance();
    logic          st, wbw;
    logic [AW-1:0] wba;
    logic [DW-1:0] wbd;
    rec_t          n;
    st  = ref_stall();
    wbw = ref_wb_we();
    wba = m[2].rd;
    wbd = ref_wb_data();
    @(posedge clk);
    if (!reset) begin
      clear_model();
    end else begin
      m[2] = m[1];
      m[2].lddata = mem_load_data;
      m[1] = m[0];
      m[1].alu = ex_alu_result;
      if (st || flush || !id_valid) begin
        m[0] = bubble();
      end else begin
        n = bubble();
        n.v = 1; n.wr = id_reg_write; n.ld = id_mem_read;
        n.rd = id_rd; n.rs = id_rs; n.rt = id_rt;
        n.rsd = id_rs_data; n.rtd = id_rt_data;
`ifdef PIPE_HAZARD_WB_BYPASS_EN
        if (wbw && wba == id_rs) n.rsd = wbd;
        if (wbw && wba == id_rt) n.rtd = wbd;
`endif
        m[0] = n;
      end
      if (st) stalls++;
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic ut, input logic [AW-1:0] rd, input logic we,
                        input logic mr, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut; id_rd = rd;
    id_reg_write = we; id_mem_read = mr; id_rs_data = rsd; id_rt_data = rtd;
  endtask

  task automatic idle();
    set_id(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    ex_alu_result = '0;
    mem_load_data = '0;
    idle();
    clear_model();

    sample();
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_addr", wb_addr, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_op_a", ex_op_a, 32'd0);
    chk("rst_op_b", ex_op_b, 32'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    advance();
    reset = 1'b1;

    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 32'h10, 32'h20);
    sample(); advance();
    set_id(1'b1, 5'd3, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 32'hBAD, 32'h30);
    ex_alu_result = 32'd5;
    sample();
    chk("add_fwd_stall", stall, 1'b0);
    advance();
    idle();
    ex_alu_result = 32'h99;
    sample();
    chk("add_fwd_op_a", ex_op_a, 32'd5);
    advance();
    for (int unsigned i = 0; i < 3; i++) begin sample(); advance(); end

    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h40, 32'h0);
    mem_load_data = 32'h1234;
    sample(); advance();
    set_id(1'b1, 5'd1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 32'h41, 32'hDEAD);
    sample();
    chk("lu_stall_on", stall, 1'b1);
    advance();
    sample();
    chk("lu_stall_off", stall, 1'b0);
    chk("lu_cnt", stall_cnt, 16'd1);
    advance();
    idle();
    sample();
    chk("lu_op_b", ex_op_b, 32'h1234);
    chk("lu_wb_addr", wb_addr, 5'd4);
    advance();
    for (int unsigned i = 0; i < 3; i++) begin sample(); advance(); end

    set_id(1'b1, 5'd1, 5'd1, 1'b0, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    sample(); advance();
    set_id(1'b1, 5'd1, 5'd1, 1'b0, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    ex_alu_result = 32'd9;
    sample(); advance();
    set_id(1'b1, 5'd2, 5'd1, 1'b0, 5'd8, 1'b0, 1'b0, 32'hCC, 32'h0);
    ex_alu_result = 32'd7;
    sample(); advance();
    idle();
    sample();
    chk("prio_op_a", ex_op_a, 32'd7);
    chk("prio_wb_data", wb_data, 32'd9);
    advance();
    for (int unsigned i = 0; i < 3; i++) begin sample(); advance(); end

    set_id(1'b1, 5'd1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    sample(); advance();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h55, 32'h66);
    ex_alu_result = 32'hFF;
    sample(); advance();
    idle();
    sample();
    chk("r0_op_a", ex_op_a, 32'h55);
    chk("r0_op_b", ex_op_b, 32'h66);
    advance();
    sample();
    chk("r0_wb_we", wb_we, 1'b0);
    advance();
    for (int unsigned i = 0; i < 3; i++) begin sample(); advance(); end

    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h0, 32'h0);
    sample(); advance();
    set_id(1'b1, 5'd4, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0);
    flush = 1'b1;
    sample();
    chk("fl_stall", stall, 1'b0);
    advance();
    flush = 1'b0;
    idle();
    sample();
    chk("fl_cnt", stall_cnt, 16'd1);
    advance();
    sample(); advance();
    sample();
    chk("fl_bubble_wb_we", wb_we, 1'b0);
    advance();

    for (int unsigned p = 0; p < 5; p++) begin
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h0, 32'h0);
      mem_load_data = $urandom;
      sample(); advance();
      set_id(1'b1, 5'd4, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0);
      sample(); advance();
      sample(); advance();
      idle();
      sample(); advance();
    end
    sample();
    chk("sat_cnt_full", stall_cnt, 16'd6);
    chk("sat_cnt_2bit", s_stall_cnt, 2'd3);
    advance();

    set_id(1'b1, 5'd1, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0);
    sample(); advance();
    idle();
    ex_alu_result = 32'h77;
    sample(); advance();
    reset = 1'b0;
    clear_model();
    sample();
    chk("mrst_wb_we", wb_we, 1'b0);
    chk("mrst_cnt", stall_cnt, 16'd0);
    advance();
    reset = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      sample();
      chk("mrst_no_wb", wb_we, 1'b0);
      advance();
    end

    set_id(1'b1, 5'd1, 5'd1, 1'b0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0);
    sample(); advance();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    ex_alu_result = 32'hAB;
    sample(); advance();
    ex_alu_result = 32'h0;
    sample(); advance();
    set_id(1'b1, 5'd6, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 32'h11, 32'h22);
    sample();
    chk("byp_wb_data", wb_data, 32'hAB);
    advance();
    idle();
    sample();
`ifdef PIPE_HAZARD_WB_BYPASS_EN
    chk("byp_op_a", ex_op_a, 32'hAB);
`else
    chk("byp_op_a", ex_op_a, 32'h11);
`endif
    advance();

    for (int unsigned i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 9) != 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, $urandom);
      flush = ($urandom_range(0, 9) == 0);
      ex_alu_result = $urandom;
      mem_load_data = $urandom;
      sample(); advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
